// File: rtl/seg_scan_ctrl.sv
// Four-digit HH:MM common-anode 7-segment scan controller.
// One shared segment bus; each digit slot opens with an all-anodes-off blank interval.

module seg_digit_enc (
  input  logic [3:0] sym_i,
  output logic [6:0] seg_o
);
  // sym_i: 0..9 digit, 10 blank, 11 dash; {g,f,e,d,c,b,a} active-low
  always_comb begin
    seg_o = 7'h7F;
    case (sym_i)
      4'd0:  seg_o = 7'h40;
      4'd1:  seg_o = 7'h79;
      4'd2:  seg_o = 7'h24;
      4'd3:  seg_o = 7'h30;
      4'd4:  seg_o = 7'h19;
      4'd5:  seg_o = 7'h12;
      4'd6:  seg_o = 7'h02;
      4'd7:  seg_o = 7'h78;
      4'd8:  seg_o = 7'h00;
      4'd9:  seg_o = 7'h10;
      4'd11: seg_o = 7'h3F;
      default: seg_o = 7'h7F;
    endcase
  end
endmodule

module seg_scan_ctrl #(
  parameter int CLK_HZ    = 100_000_000,
  parameter int SCAN_HZ   = 1000,
  parameter int BLANK_CYC = 64
) (
  input  logic       clk_100MHz,
  input  logic       reset,
  input  logic [3:0] hours,
  input  logic [5:0] minutes,
  input  logic       pm,
  input  logic       sec_tick,
  input  logic       blink_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);
  localparam int NUM_DIG = 4;
  localparam int DIV     = CLK_HZ / SCAN_HZ;
  localparam int CW      = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MAX    = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [3:0] SYM_BLANK = 4'd10;
  localparam logic [3:0] SYM_DASH  = 4'd11;

  typedef enum logic {S_BLANK, S_DRIVE} state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic        colon_q;
  logic [3:0]  snap_h_q;
  logic [5:0]  snap_m_q;
  logic        snap_pm_q;
  logic [6:0]  seg_q;
  logic        dp_q;

  logic        wrap, slot_start, frame_start;
  logic [3:0]  src_h;
  logic [5:0]  src_m;
  logic        src_pm;
  logic        h_bad, m_bad, h_ten;
  logic [3:0]  h_one;
  logic [2:0]  m_tens;
  logic [5:0]  m_ones;
  logic [NUM_DIG-1:0][3:0] sym;
  logic [NUM_DIG-1:0][6:0] seg_code;
  logic        dp_d;

  assign wrap        = (cnt_q == CNT_MAX);
  assign slot_start  = (cnt_q == '0);
  assign frame_start = slot_start && (idx_q == 2'd0);

  // idx0 loads in the same cycle the snapshot is taken, so it must see the live inputs
  assign src_h  = frame_start ? hours   : snap_h_q;
  assign src_m  = frame_start ? minutes : snap_m_q;
  assign src_pm = frame_start ? pm      : snap_pm_q;

  always_comb begin
    h_bad  = (src_h == 4'd0) || (src_h > 4'd12);
    m_bad  = (src_m > 6'd59);
    h_ten  = (src_h >= 4'd10);
    h_one  = h_ten ? (src_h - 4'd10) : src_h;
    m_tens = 3'd0;
    m_ones = src_m;
    for (int k = 0; k < 5; k++) begin
      if (m_ones >= 6'd10) begin
        m_ones = m_ones - 6'd10;
        m_tens = m_tens + 3'd1;
      end
    end
    sym[3] = h_bad ? SYM_DASH : (h_ten ? 4'd1 : SYM_BLANK);
    sym[2] = h_bad ? SYM_DASH : h_one;
    sym[1] = m_bad ? SYM_DASH : {1'b0, m_tens};
    sym[0] = m_bad ? SYM_DASH : m_ones[3:0];
  end

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
    seg_digit_enc u_enc (
      .sym_i (sym[g]),
      .seg_o (seg_code[g])
    );
  end

  always_comb begin
    dp_d = 1'b1;
    case (idx_q)
      2'd0: dp_d = ~src_pm;
      2'd2: dp_d = ~(~blink_en | colon_q);
      default: dp_d = 1'b1;
    endcase
  end

  always_comb begin
    cnt_d   = wrap ? '0 : cnt_q + CW'(1);
    idx_d   = wrap ? idx_q + 2'd1 : idx_q;
    state_d = state_q;
    an      = 4'hF;
    case (state_q)
      S_BLANK: if (!wrap && cnt_q == BLANK_LAST) state_d = S_DRIVE;
      S_DRIVE: begin
        an = ~(4'b0001 << idx_q);
        if (wrap) state_d = S_BLANK;
      end
      default: state_d = S_BLANK;
    endcase
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) state_q <= S_BLANK;
    else       state_q <= state_d;
  end

  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      cnt_q     <= '0;
      idx_q     <= 2'd0;
      colon_q   <= 1'b1;
      snap_h_q  <= 4'd0;
      snap_m_q  <= 6'd0;
      snap_pm_q <= 1'b0;
      seg_q     <= 7'h7F;
      dp_q      <= 1'b1;
    end else begin
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      if (sec_tick) colon_q <= ~colon_q;
      if (frame_start) begin
        snap_h_q  <= hours;
        snap_m_q  <= minutes;
        snap_pm_q <= pm;
      end
      if (slot_start) begin
        seg_q <= seg_code[idx_q];
        dp_q  <= dp_d;
      end
    end
  end

  assign seg = seg_q;
  assign dp  = dp_q;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed steps plus random inputs against a time-indexed display model.
module tb_seg_scan_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] hours;
  logic [5:0] minutes;
  logic       pm, sec_tick, blink_en;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;

  int checks = 0;
  int errors = 0;

  // model: t = cycles since reset release; slot = t/10, digit = slot%4
  int t = 0;
  int ticks = 0;
  int sh = 0, sm = 0, spm = 0;
  logic [6:0] exp_seg = 7'h7F;
  logic       exp_dp  = 1'b1;
  logic [6:0] segt [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  seg_scan_ctrl #(.CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2)) dut (
    .clk_100MHz (clk),
    .reset      (reset),
    .hours      (hours),
    .minutes    (minutes),
    .pm         (pm),
    .sec_tick   (sec_tick),
    .blink_en   (blink_en),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(int d, int h, int m);
    logic hbad, mbad;
    hbad = (h < 1) || (h > 12);
    mbad = (m > 59);
    case (d)
      3: return hbad ? 7'h3F : ((h >= 10) ? segt[1] : 7'h7F);
      2: return hbad ? 7'h3F : segt[h % 10];
      1: return mbad ? 7'h3F : segt[m / 10];
      default: return mbad ? 7'h3F : segt[m % 10];
    endcase
  endfunction

  task automatic check(string tag, logic [7:0] obs, logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic cycle();
    logic [3:0] ea;
    int idx;
    @(negedge clk);
    idx = (t / 10) % 4;
    ea  = (t % 10 < 2) ? 4'hF : ~(4'b0001 << idx);
    check("an",  {4'h0, an},  {4'h0, ea});
    check("seg", {1'b0, seg}, {1'b0, exp_seg});
    check("dp",  {7'h0, dp},  {7'h0, exp_dp});
    if (reset) begin
      t = 0; ticks = 0; sh = 0; sm = 0; spm = 0;
      exp_seg = 7'h7F; exp_dp = 1'b1;
    end else begin
      if (t % 10 == 0) begin
        if (idx == 0) begin sh = hours; sm = minutes; spm = pm; end
        exp_seg = ref_seg(idx, sh, sm);
        if (idx == 0)      exp_dp = (spm == 0);
        else if (idx == 2) exp_dp = blink_en && (ticks % 2 == 1);
        else               exp_dp = 1'b1;
      end
      if (sec_tick) ticks++;
      t++;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; hours = 4'd10; minutes = 6'd45; pm = 1'b1;
    sec_tick = 1'b0; blink_en = 1'b0;
    @(posedge clk); #1;
    repeat (3) cycle();
    reset = 1'b0;
    repeat (90) cycle();

    hours = 4'd7; minutes = 6'd3; pm = 1'b0;
    repeat (80) cycle();
    hours = 4'd0; minutes = 6'd60;
    repeat (80) cycle();
    hours = 4'd12; minutes = 6'd0;
    repeat (80) cycle();

    hours = 4'd9;
    repeat (40) cycle();
    for (int k = 0; k < 40 && (t % 40 != 25); k++) cycle();
    hours = 4'd11;
    repeat (60) cycle();

    blink_en = 1'b1;
    for (int s = 0; s < 6; s++) begin
      sec_tick = 1'b1; cycle(); sec_tick = 1'b0;
      repeat (99) cycle();
    end
    // tick landing on the colon slot's first cycle
    for (int k = 0; k < 40 && (t % 40 != 20); k++) cycle();
    sec_tick = 1'b1; cycle(); sec_tick = 1'b0;
    repeat (60) cycle();

    repeat (3000) begin
      if ($urandom_range(0, 19) == 0) begin
        hours    = 4'($urandom_range(0, 15));
        minutes  = 6'($urandom_range(0, 63));
        pm       = 1'($urandom_range(0, 1));
        blink_en = 1'($urandom_range(0, 1));
      end
      sec_tick = ($urandom_range(0, 29) == 0);
      cycle();
    end
    sec_tick = 1'b0;

    blink_en = 1'b1;
    if (ticks % 2 == 0) begin sec_tick = 1'b1; cycle(); sec_tick = 1'b0; end
    for (int k = 0; k < 10 && (t % 10 != 5); k++) cycle();
    reset = 1'b1; cycle();
    reset = 1'b0;
    repeat (80) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
